zombie_wave_ctrl: RTL and testbench

//  Consumer end of the level-control interface. Takes per-zombie speed/spawn-delay and the new_level

---
 rtl/zombie_wave_ctrl_pkg.sv | 36 +++
 rtl/zombie_wave_ctrl_slot.sv | 84 ++++++++
 rtl/zombie_wave_ctrl.sv | 71 +++++++
 tb/tb_zombie_wave_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zombie_wave_ctrl_pkg.sv
// Shared game types and constants for the zombie wave controller and the sprite renderer.
package zombie_wave_ctrl_pkg;

    localparam int NUM_ZOMBIES  = 3;
    localparam int SPAWN_Y0     = 100;
    localparam int SPAWN_Y_STEP = 120;

    typedef logic [9:0] coord_t;
    typedef logic [4:0] cool_t;
    typedef enum logic [1:0] {IDLE, WAIT, ALIVE, DEAD} slot_state_t;

    localparam coord_t SPAWN_X      = 10'd620;
    localparam coord_t HIT_DIST     = 10'd16;
    localparam coord_t COUNT_MAX    = 10'd1023;
    localparam cool_t  HIT_COOLDOWN = 5'd30;

    function automatic coord_t spawn_y(input int idx);
        return coord_t'(SPAWN_Y0 + idx * SPAWN_Y_STEP);
    endfunction

    // Move toward the target by at most 'speed', clamping so the step never overshoots.
    function automatic coord_t step_toward(input coord_t pos, input coord_t target, input coord_t speed);
        coord_t diff;
        coord_t stepAmt;
        diff    = (target >= pos) ? target - pos : pos - target;
        stepAmt = (speed < diff) ? speed : diff;
        return (target >= pos) ? pos + stepAmt : pos - stepAmt;
    endfunction

    function automatic logic within_hit(input coord_t a, input coord_t b);
        coord_t diff;
        diff = (a >= b) ? a - b : b - a;
        return diff < HIT_DIST;
    endfunction

endpackage

// File: rtl/zombie_wave_ctrl_slot.sv
// One zombie slot: spawn-delay counter, chase mover, contact cooldown and IDLE/WAIT/ALIVE/DEAD FSM.
module zombie_slot
    import zombie_wave_ctrl_pkg::*;
#(
    parameter coord_t SPAWN_Y = 10'd100
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        tick_i,
    input  logic        new_level_i,
    input  logic        play_active_i,
    input  logic [9:0]  speed_i,
    input  logic [9:0]  delay_i,
    input  logic [9:0]  player_x_i,
    input  logic [9:0]  player_y_i,
    input  logic        bullet_hit_i,
    output logic [9:0]  x_o,
    output logic [9:0]  y_o,
    output slot_state_t state_o,
    output logic        hit_req_o
);

    slot_state_t state_q;
    coord_t      count_q, count_d;
    coord_t      x_q, x_d;
    coord_t      y_q, y_d;
    cool_t       cool_q, cool_d;
    logic        stepEn;
    logic        contact;
    logic        hitReq;

    assign stepEn = tick_i & play_active_i;

    // Contact is judged on the post-move position with the already-decremented cooldown.
    always_comb begin
        count_d = (count_q == COUNT_MAX) ? count_q : count_q + 10'd1;
        x_d     = step_toward(x_q, player_x_i, speed_i);
        y_d     = step_toward(y_q, player_y_i, speed_i);
        cool_d  = (cool_q == '0) ? '0 : cool_q - 5'd1;
        contact = (cool_d == '0) && within_hit(x_d, player_x_i) && within_hit(y_d, player_y_i);
        hitReq  = (state_q == ALIVE) && stepEn && !bullet_hit_i && !new_level_i && contact;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= '0;
            x_q     <= SPAWN_X;
            y_q     <= SPAWN_Y;
            cool_q  <= '0;
        end else if (new_level_i) begin
            state_q <= WAIT;
            count_q <= '0;
            x_q     <= SPAWN_X;
            y_q     <= SPAWN_Y;
            cool_q  <= '0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (stepEn) begin
                        count_q <= count_d;
                        if (count_d >= delay_i) state_q <= ALIVE;
                    end
                end
                ALIVE: begin
                    if (bullet_hit_i) begin
                        state_q <= DEAD;
                    end else if (stepEn) begin
                        x_q    <= x_d;
                        y_q    <= y_d;
                        cool_q <= contact ? HIT_COOLDOWN : cool_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign state_o   = state_q;
    assign hit_req_o = hitReq;

endmodule

// File: rtl/zombie_wave_ctrl.sv
// Zombie wave controller: frame-tick detector, NUM_ZOMBIES slots, enemies flag and player_hit pulse.
module zombie_wave_ctrl
    import zombie_wave_ctrl_pkg::*;
(
    input  logic                        Clk,
    input  logic                        Reset_h,
    input  logic                        frame_clk,
    input  logic                        new_level,
    input  logic                        play_active,
    input  logic [NUM_ZOMBIES-1:0][9:0] zombie_speed,
    input  logic [NUM_ZOMBIES-1:0][9:0] zombie_delay_spawn,
    input  logic [9:0]                  player_x,
    input  logic [9:0]                  player_y,
    input  logic [NUM_ZOMBIES-1:0]      bullet_hit,
    output logic [NUM_ZOMBIES-1:0][9:0] zombie_x,
    output logic [NUM_ZOMBIES-1:0][9:0] zombie_y,
    output logic [NUM_ZOMBIES-1:0]      zombie_alive,
    output logic                        enemies,
    output logic                        player_hit
);

    logic                   frame_q;
    logic                   player_hit_q;
    logic                   tick;
    logic [NUM_ZOMBIES-1:0] hitReq;
    slot_state_t            slotState [NUM_ZOMBIES];

    assign tick = frame_clk & ~frame_q;

    for (genvar i = 0; i < NUM_ZOMBIES; i++) begin : g_slot
        zombie_slot #(
            .SPAWN_Y(spawn_y(i))
        ) u_slot (
            .clk_i        (Clk),
            .reset_i      (Reset_h),
            .tick_i       (tick),
            .new_level_i  (new_level),
            .play_active_i(play_active),
            .speed_i      (zombie_speed[i]),
            .delay_i      (zombie_delay_spawn[i]),
            .player_x_i   (player_x),
            .player_y_i   (player_y),
            .bullet_hit_i (bullet_hit[i]),
            .x_o          (zombie_x[i]),
            .y_o          (zombie_y[i]),
            .state_o      (slotState[i]),
            .hit_req_o    (hitReq[i])
        );
        assign zombie_alive[i] = (slotState[i] == ALIVE);
    end

    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            frame_q      <= 1'b0;
            player_hit_q <= 1'b0;
        end else begin
            frame_q      <= frame_clk;
            player_hit_q <= |hitReq;
        end
    end

    always_comb begin
        enemies = 1'b0;
        for (int i = 0; i < NUM_ZOMBIES; i++) begin
            enemies = enemies | (slotState[i] == WAIT) | (slotState[i] == ALIVE);
        end
    end

    assign player_hit = player_hit_q;

endmodule

// File: tb/tb_zombie_wave_ctrl.sv
// Bench for zombie_wave_ctrl: directed scenarios plus random traffic against a behavioural slot model.
module tb_zombie_wave_ctrl;

    localparam int N = 3;
    localparam int P_IDLE = 0, P_WAIT = 1, P_ALIVE = 2, P_DEAD = 3;

    logic              Clk = 1'b0;
    logic              Reset_h = 1'b1;
    logic              frame_clk = 1'b0;
    logic              new_level = 1'b0;
    logic              play_active = 1'b1;
    logic [N-1:0][9:0] zombie_speed = '0;
    logic [N-1:0][9:0] zombie_delay_spawn = '0;
    logic [9:0]        player_x = '0;
    logic [9:0]        player_y = '0;
    logic [N-1:0]      bullet_hit = '0;
    logic [N-1:0][9:0] zombie_x;
    logic [N-1:0][9:0] zombie_y;
    logic [N-1:0]      zombie_alive;
    logic              enemies;
    logic              player_hit;

    int testsRun = 0;
    int testsFailed = 0;

    int mPhase [N];
    int mCount [N];
    int mX [N];
    int mY [N];
    int mCool [N];
    bit mHitQ = 0;
    bit mFramePrev = 0;

    always #5 Clk = ~Clk;

    zombie_wave_ctrl dut (
        .Clk               (Clk),
        .Reset_h           (Reset_h),
        .frame_clk         (frame_clk),
        .new_level         (new_level),
        .play_active       (play_active),
        .zombie_speed      (zombie_speed),
        .zombie_delay_spawn(zombie_delay_spawn),
        .player_x          (player_x),
        .player_y          (player_y),
        .bullet_hit        (bullet_hit),
        .zombie_x          (zombie_x),
        .zombie_y          (zombie_y),
        .zombie_alive      (zombie_alive),
        .enemies           (enemies),
        .player_hit        (player_hit)
    );

    function automatic int absDiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int approach(input int pos, input int tgt, input int spd);
        int mv;
        mv = (spd < absDiff(pos, tgt)) ? spd : absDiff(pos, tgt);
        return (tgt > pos) ? pos + mv : pos - mv;
    endfunction

    // Advance the game-rule model by one clock using the inputs currently applied.
    task automatic modelStep();
        bit tickNow;
        bit reqAny;
        tickNow = frame_clk && !mFramePrev;
        reqAny = 0;
        for (int i = 0; i < N; i++) begin
            if (Reset_h || new_level) begin
                mPhase[i] = Reset_h ? P_IDLE : P_WAIT;
                mCount[i] = 0;
                mX[i] = 620;
                mY[i] = 100 + 120 * i;
                mCool[i] = 0;
            end else if (mPhase[i] == P_ALIVE && bullet_hit[i]) begin
                mPhase[i] = P_DEAD;
            end else if (tickNow && play_active) begin
                if (mPhase[i] == P_WAIT) begin
                    if (mCount[i] < 1023) mCount[i]++;
                    if (mCount[i] >= int'(zombie_delay_spawn[i])) mPhase[i] = P_ALIVE;
                end else if (mPhase[i] == P_ALIVE) begin
                    mX[i] = approach(mX[i], int'(player_x), int'(zombie_speed[i]));
                    mY[i] = approach(mY[i], int'(player_y), int'(zombie_speed[i]));
                    if (mCool[i] > 0) mCool[i]--;
                    if (mCool[i] == 0 && absDiff(mX[i], int'(player_x)) < 16 &&
                        absDiff(mY[i], int'(player_y)) < 16) begin
                        reqAny = 1;
                        mCool[i] = 30;
                    end
                end
            end
        end
        mHitQ = Reset_h ? 1'b0 : reqAny;
        mFramePrev = Reset_h ? 1'b0 : frame_clk;
    endtask

    task automatic compareVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        bit anyEnemy;
        anyEnemy = 0;
        for (int i = 0; i < N; i++) begin
            compareVal($sformatf("zombie_x[%0d]", i), 32'(zombie_x[i]), mX[i]);
            compareVal($sformatf("zombie_y[%0d]", i), 32'(zombie_y[i]), mY[i]);
            compareVal($sformatf("zombie_alive[%0d]", i), 32'(zombie_alive[i]), 32'(mPhase[i] == P_ALIVE));
            if (mPhase[i] == P_WAIT || mPhase[i] == P_ALIVE) anyEnemy = 1;
        end
        compareVal("enemies", 32'(enemies), 32'(anyEnemy));
        compareVal("player_hit", 32'(player_hit), 32'(mHitQ));
    endtask

    task automatic applyStimulus();
        modelStep();
        @(posedge Clk);
        #1;
        checkOutput();
    endtask

    task automatic frameTicks(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            applyStimulus();
            frame_clk = 1'b0;
            applyStimulus();
        end
    endtask

    task automatic startLevel(input int d0, input int d1, input int d2, input int s0, input int s1, input int s2);
        zombie_delay_spawn[0] = 10'(d0);
        zombie_delay_spawn[1] = 10'(d1);
        zombie_delay_spawn[2] = 10'(d2);
        zombie_speed[0] = 10'(s0);
        zombie_speed[1] = 10'(s1);
        zombie_speed[2] = 10'(s2);
        new_level = 1'b1;
        applyStimulus();
        new_level = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int hitCount;
        int firstHit;
        int secondHit;

        Reset_h = 1'b1;
        applyStimulus();
        applyStimulus();
        compareVal("reset x0", 32'(zombie_x[0]), 620);
        compareVal("reset y1", 32'(zombie_y[1]), 220);
        compareVal("reset y2", 32'(zombie_y[2]), 340);
        compareVal("reset enemies", 32'(enemies), 0);
        Reset_h = 1'b0;
        applyStimulus();

        // Spawn delays of 100/400/600 ticks with everything stationary and the player far away.
        startLevel(100, 400, 600, 0, 0, 0);
        compareVal("lvl enemies", 32'(enemies), 1);
        compareVal("lvl alive", 32'(zombie_alive), 0);
        frameTicks(99);
        compareVal("alive@99", 32'(zombie_alive), 3'b000);
        frameTicks(1);
        compareVal("alive@100", 32'(zombie_alive), 3'b001);
        frameTicks(299);
        compareVal("alive@399", 32'(zombie_alive), 3'b001);
        frameTicks(1);
        compareVal("alive@400", 32'(zombie_alive), 3'b011);
        frameTicks(199);
        compareVal("alive@599", 32'(zombie_alive), 3'b011);
        frameTicks(1);
        compareVal("alive@600", 32'(zombie_alive), 3'b111);

        // Chase at speed 3 from 620 toward 300, clamping at the player.
        player_x = 10'd300;
        player_y = 10'd100;
        startLevel(0, 1023, 1023, 3, 0, 0);
        frameTicks(1);
        compareVal("chase spawn x", 32'(zombie_x[0]), 620);
        compareVal("chase alive0", 32'(zombie_alive[0]), 1);
        frameTicks(1);
        compareVal("chase x1", 32'(zombie_x[0]), 617);
        frameTicks(1);
        compareVal("chase x2", 32'(zombie_x[0]), 614);
        frameTicks(120);
        compareVal("chase stop x", 32'(zombie_x[0]), 300);
        compareVal("chase y", 32'(zombie_y[0]), 100);

        // Parked on the player: pulse on first ALIVE tick, then every 30 ticks, one cycle wide.
        player_x = 10'd620;
        startLevel(0, 1023, 1023, 0, 0, 0);
        frameTicks(1);
        hitCount = 0;
        firstHit = -1;
        secondHit = -1;
        for (int t = 1; t <= 61; t++) begin
            frame_clk = 1'b1;
            applyStimulus();
            if (player_hit === 1'b1) begin
                hitCount++;
                if (firstHit < 0) firstHit = t;
                else if (secondHit < 0) secondHit = t;
            end
            frame_clk = 1'b0;
            applyStimulus();
            compareVal("hit width", 32'(player_hit), 0);
        end
        compareVal("hit count", 32'(hitCount), 3);
        compareVal("first hit tick", 32'(firstHit), 1);
        compareVal("second hit tick", 32'(secondHit), 31);

        // Kills: ignored while waiting, enemies drops after the last kill.
        player_x = 10'd0;
        player_y = 10'd0;
        startLevel(0, 0, 0, 0, 0, 0);
        bullet_hit = 3'b111;
        applyStimulus();
        bullet_hit = 3'b000;
        compareVal("wait kill enemies", 32'(enemies), 1);
        frameTicks(1);
        compareVal("all alive", 32'(zombie_alive), 3'b111);
        bullet_hit = 3'b001;
        applyStimulus();
        bullet_hit = 3'b010;
        applyStimulus();
        compareVal("two killed enemies", 32'(enemies), 1);
        bullet_hit = 3'b100;
        applyStimulus();
        bullet_hit = 3'b000;
        compareVal("all killed enemies", 32'(enemies), 0);

        // Kill coincident with a contact tick wins; new_level mid-chase respawns with count 0.
        player_x = 10'd620;
        player_y = 10'd100;
        startLevel(0, 1023, 1023, 0, 0, 0);
        frameTicks(1);
        frame_clk = 1'b1;
        bullet_hit = 3'b001;
        applyStimulus();
        bullet_hit = 3'b000;
        frame_clk = 1'b0;
        compareVal("kill vs contact alive", 32'(zombie_alive[0]), 0);
        compareVal("kill vs contact hit", 32'(player_hit), 0);
        applyStimulus();
        compareVal("kill vs contact hit+1", 32'(player_hit), 0);
        player_x = 10'd300;
        startLevel(0, 1023, 1023, 5, 0, 0);
        frameTicks(5);
        compareVal("mid chase x", 32'(zombie_x[0]), 600);
        startLevel(2, 1023, 1023, 5, 0, 0);
        compareVal("respawn x", 32'(zombie_x[0]), 620);
        compareVal("respawn alive", 32'(zombie_alive[0]), 0);
        frameTicks(1);
        compareVal("respawn tick1", 32'(zombie_alive[0]), 0);
        frameTicks(1);
        compareVal("respawn tick2", 32'(zombie_alive[0]), 1);

        // play_active low freezes the wait count; reset mid-level clears everything.
        player_x = 10'd0;
        player_y = 10'd0;
        startLevel(60, 1023, 1023, 0, 0, 0);
        frameTicks(20);
        play_active = 1'b0;
        frameTicks(50);
        compareVal("paused alive", 32'(zombie_alive[0]), 0);
        play_active = 1'b1;
        frameTicks(39);
        compareVal("resume 59", 32'(zombie_alive[0]), 0);
        frameTicks(1);
        compareVal("resume 60", 32'(zombie_alive[0]), 1);
        Reset_h = 1'b1;
        applyStimulus();
        Reset_h = 1'b0;
        compareVal("mid reset enemies", 32'(enemies), 0);
        compareVal("mid reset alive", 32'(zombie_alive), 0);
        compareVal("mid reset x0", 32'(zombie_x[0]), 620);
        compareVal("mid reset hit", 32'(player_hit), 0);

        // Random traffic with live speed/delay changes, checked every cycle by the model.
        startLevel(5, 10, 15, 4, 7, 2);
        for (int c = 0; c < 4000; c++) begin
            frame_clk = 1'($urandom_range(0, 1));
            new_level = ($urandom_range(0, 199) == 0);
            Reset_h = ($urandom_range(0, 999) == 0);
            play_active = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                bullet_hit[i] = ($urandom_range(0, 39) == 0);
            end
            if (c % 64 == 0) begin
                player_x = 10'($urandom_range(0, 639));
                player_y = 10'($urandom_range(0, 479));
                for (int i = 0; i < N; i++) begin
                    zombie_speed[i] = 10'($urandom_range(0, 20));
                    zombie_delay_spawn[i] = 10'($urandom_range(0, 30));
                end
            end
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
